shift_reg_sipo_rx: RTL and testbench
====================================

SHIFT_REG_SIPO_RX -- requirements
Module: shift_reg_sipo_rx

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the number of data bits per word (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1, SHALL select shift order: 1 means the first received bit lands in q[WIDTH-1]; 0 means it lands in q[0].
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 sdi  input  1  SHALL carry serial data, sampled only when sdi_en=1.
REQ-006 sdi_en  input  1  SHALL be the bit strobe; each clk edge with sdi_en=1 accepts exactly one bit.
REQ-007 clear  input  1  SHALL be a synchronous abort of the partial word in progress.
REQ-008 q  output  WIDTH  SHALL carry the assembled parallel word.
REQ-009 q_valid  output  1  SHALL indicate that q holds an undelivered word.
REQ-010 q_ready  input  1  SHALL be the consumer acceptance signal.
REQ-011 busy  output  1  SHALL be 1 whenever a partial word is in progress (bit count != 0).
REQ-012 overrun  output  1  SHALL be the sticky lost-word flag.
REQ-013 par_err  output  1  SHALL be the parity error flag qualified by q_valid.

Function
REQ-014 Receive states SHALL be RX_DATA, and RX_PARITY when parity is enabled; the output hold register SHALL carry a separate full flag, which is q_valid.
REQ-015 In RX_DATA, each accepted bit SHALL shift in as follows: MSB_FIRST=1 gives sr <= {sr[WIDTH-2:0], sdi}; MSB_FIRST=0 gives sr <= {sdi, sr[WIDTH-1:1]}. The bit count SHALL increment by 1.
REQ-016 Clock cycles with sdi_en=0 SHALL leave sr, the bit count and the state unchanged, so gaps of any length are allowed.
REQ-017 On the edge that accepts the last bit of a frame, the word is complete: the next sr value SHALL be loaded into q, q_valid SHALL be set, the count SHALL return to 0 and the state SHALL return to RX_DATA. q_valid is visible in the cycle after that edge.
REQ-018 A delivery handshake occurs on any edge where q_valid=1 and q_ready=1; it SHALL clear q_valid unless a word completes on the same edge.
REQ-019 If a word completes on the same edge as a handshake, the new word SHALL load and q_valid SHALL stay 1, giving back-to-back delivery with no bubble.
REQ-020 If a word completes while q_valid=1 and q_ready=0, the new word SHALL be discarded, q SHALL hold its old value, and overrun SHALL be set to 1.
REQ-021 overrun SHALL remain 1 until reset or clear.
REQ-022 q SHALL change only on a word load, and SHALL hold stable while q_valid=1 and q_ready=0.
REQ-023 clear=1 SHALL set the count to 0, sr to 0, overrun to 0 and the state to RX_DATA; clear SHALL NOT alter q or q_valid.
REQ-024 clear=1 together with sdi_en=1 SHALL discard that bit, because clear has priority.
REQ-025 busy SHALL be a registered decode of count != 0, and SHALL return to 0 in the cycle after word completion.

Reset
REQ-026 reset=1 SHALL, at the next clk edge, set sr=0, count=0, state=RX_DATA, q=0, q_valid=0, overrun=0, par_err=0 and busy=0.
REQ-027 reset SHALL override clear, sdi_en and q_ready, and SHALL drop any partial word or undelivered word present when it is asserted.

Configuration
REQ-028 Macro SIPO_PARITY_EN SHALL select whether the parity feature is compiled in.
REQ-029 With SIPO_PARITY_EN defined:
- after WIDTH data bits the state SHALL move to RX_PARITY;
- the next accepted bit is the even-parity bit and completes the word;
- par_err SHALL load with (XOR of the data bits XOR the parity bit) alongside q, and the word SHALL be delivered regardless of par_err;
- on an overrun, par_err SHALL keep its old value.
REQ-030 Without SIPO_PARITY_EN, RX_PARITY SHALL not exist, a frame SHALL be exactly WIDTH bits, and par_err SHALL be tied to 0.

Verification
REQ-031 The bench SHALL cover the following directed scenarios. Unless a scenario says otherwise, WIDTH=4, MSB_FIRST=1, and SIPO_PARITY_EN is not defined.
- Reset: hold reset for 2 cycles with sdi_en=1 -> q=0, q_valid=0, busy=0, overrun=0.
- Basic word: sdi_en=1 for 4 consecutive cycles with bits 0,1,0,1 -> q=4'b0101, q_valid=1 one cycle after the 4th edge. Then q_ready=1 for 1 cycle -> q_valid=0.
- Gaps and order: bits 1,1,0,1 with 3 idle cycles between the 2nd and 3rd bits -> q=4'b1101. Repeat with MSB_FIRST=0 and bits 1,0,1,0 -> q=4'b0101.
- Overrun: word 0101 held with q_ready=0, then bits 1,1,1,1 -> q stays 4'b0101, overrun=1. A clear pulse -> overrun=0 and q_valid still 1.
- Back-to-back: q_ready=1 on the edge that accepts the last bit of the second word -> q updates directly from the first word to the second, and q_valid never drops.
- Parity (SIPO_PARITY_EN defined): bits 0,1,0,1 then parity 1 -> q=4'b0101, par_err=1. Bits 0,1,0,1 then parity 0 -> par_err=0. Also clear asserted after 2 bits -> busy=0 and the next 5 bits form a fresh word.

Source files
------------

// File: rtl/shift_reg_sipo_rx_if.sv
// Serial-in / parallel-out receiver bus.
// The master side drives serial bits, the abort strobe and the consumer
// acceptance signal. The slave side (the receiver) returns the assembled
// word and its status flags.
interface shift_reg_sipo_rx_if #(
   parameter int WIDTH = 4
);
   logic             sdi;
   logic             sdi_en;
   logic             clear;
   logic             q_ready;
   logic [WIDTH-1:0] q;
   logic             q_valid;
   logic             busy;
   logic             overrun;
   logic             par_err;

   modport master (
      output sdi, sdi_en, clear, q_ready,
      input  q, q_valid, busy, overrun, par_err
   );

   modport slave (
      input  sdi, sdi_en, clear, q_ready,
      output q, q_valid, busy, overrun, par_err
   );
endinterface

// File: rtl/shift_reg_sipo_rx.sv
// Serial-in / parallel-out receiver with a single-entry output hold register.
// Bits are accepted on sdi_en strobes and shifted into r_sr. A completed
// frame is copied into r_q, and r_q_valid marks it as undelivered until
// the consumer takes it with q_ready. A frame that completes while the
// previous word is still undelivered is dropped and the sticky overrun
// flag is raised.
// Build option: define SIPO_PARITY_EN to append an even-parity bit to every
// frame and report mismatches on par_err. Without it, par_err is tied to 0.
module shift_reg_sipo_rx #(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input logic                clk,
   input logic                reset,
   shift_reg_sipo_rx_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

`ifdef SIPO_PARITY_EN
   typedef enum logic {RX_DATA, RX_PARITY} rx_state_t;
`else
   typedef enum logic [0:0] {RX_DATA} rx_state_t;
`endif

   rx_state_t        r_state;
   logic [WIDTH-1:0] r_sr;
   logic [CW-1:0]    r_count;
   logic             r_busy;
   logic [WIDTH-1:0] r_q;
   logic             r_q_valid;
   logic             r_overrun;

   logic [WIDTH-1:0] w_sr_next;
   logic             w_last_data;
   logic             w_complete;
   logic [WIDTH-1:0] w_word;

   // Shift direction is fixed by the MSB_FIRST parameter at elaboration time.
   if (MSB_FIRST != 0) begin : g_msb_first
      assign w_sr_next = {r_sr[WIDTH-2:0], bus.sdi};
   end else begin : g_lsb_first
      assign w_sr_next = {bus.sdi, r_sr[WIDTH-1:1]};
   end

   // The current strobe carries the final data bit of the frame.
   assign w_last_data = (r_state == RX_DATA) && (r_count == CW'(WIDTH - 1));

`ifdef SIPO_PARITY_EN
   logic r_par_err;
   logic w_par_bad;

   // The frame ends on the parity bit. The data bits already sit in r_sr.
   assign w_complete = bus.sdi_en && !bus.clear && (r_state == RX_PARITY);
   assign w_word     = r_sr;
   assign w_par_bad  = (^r_sr) ^ bus.sdi;
   assign bus.par_err = r_par_err & r_q_valid;
`else
   // The frame ends on the last data bit. The word is the post-shift value.
   assign w_complete = bus.sdi_en && !bus.clear && w_last_data;
   assign w_word     = w_sr_next;
   assign bus.par_err = 1'b0;
`endif

   assign bus.q       = r_q;
   assign bus.q_valid = r_q_valid;
   assign bus.busy    = r_busy;
   assign bus.overrun = r_overrun;

   // Receive FSM, shift register, bit counter and output hold register.
   // NOTE: every register here uses non-blocking assignment. Each branch then
   // reads the pre-edge values, so the order of statements inside the block
   // does not matter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= RX_DATA;
         r_sr      <= '0;
         r_count   <= '0;
         r_busy    <= 1'b0;
         r_q       <= '0;
         r_q_valid <= 1'b0;
         r_overrun <= 1'b0;
`ifdef SIPO_PARITY_EN
         r_par_err <= 1'b0;
`endif
      end else begin
         // Receive side: clear aborts the partial frame and wins over sdi_en.
         if (bus.clear) begin
            r_state   <= RX_DATA;
            r_sr      <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
         end else if (bus.sdi_en) begin
            case (r_state)
               RX_DATA: begin
                  r_sr <= w_sr_next;
                  if (w_last_data) begin
`ifdef SIPO_PARITY_EN
                     r_state <= RX_PARITY;
                     r_count <= r_count + CW'(1);
                     r_busy  <= 1'b1;
`else
                     r_count <= '0;
                     r_busy  <= 1'b0;
`endif
                  end else begin
                     r_count <= r_count + CW'(1);
                     r_busy  <= 1'b1;
                  end
               end
`ifdef SIPO_PARITY_EN
               RX_PARITY: begin
                  r_state <= RX_DATA;
                  r_count <= '0;
                  r_busy  <= 1'b0;
               end
`endif
               default: begin
                  r_state <= RX_DATA;
               end
            endcase
         end

         // Delivery side: a word loads if the holder is empty or is being
         // emptied on this edge. Otherwise the new word is lost and flagged.
         if (w_complete) begin
            if (!r_q_valid || bus.q_ready) begin
               r_q       <= w_word;
               r_q_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
               r_par_err <= w_par_bad;
`endif
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_q_valid && bus.q_ready) begin
            r_q_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_shift_reg_sipo_rx.sv
// Self-checking bench for shift_reg_sipo_rx.
// Two receivers, one MSB-first and one LSB-first, get the same stimulus.
// A frame-level model (a queue of received bits, with words assembled
// arithmetically) predicts every output after each clock edge. Directed
// scenarios come first and then randomized traffic.
// Define SIPO_PARITY_EN for both the bench and the RTL to test the parity build.
module tb_shift_reg_sipo_rx;

   localparam int WIDTH = 4;
`ifdef SIPO_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif

   logic clk = 1'b0;
   logic reset;
   logic sdi, sdi_en, clear, q_ready;

   int n_total = 0;
   int n_bad   = 0;

   shift_reg_sipo_rx_if #(.WIDTH(WIDTH)) if_msb ();
   shift_reg_sipo_rx_if #(.WIDTH(WIDTH)) if_lsb ();

   assign if_msb.sdi     = sdi;
   assign if_msb.sdi_en  = sdi_en;
   assign if_msb.clear   = clear;
   assign if_msb.q_ready = q_ready;
   assign if_lsb.sdi     = sdi;
   assign if_lsb.sdi_en  = sdi_en;
   assign if_lsb.clear   = clear;
   assign if_lsb.q_ready = q_ready;

   shift_reg_sipo_rx #(.WIDTH(WIDTH), .MSB_FIRST(1)) u_dut_msb (
      .clk   (clk),
      .reset (reset),
      .bus   (if_msb)
   );

   shift_reg_sipo_rx #(.WIDTH(WIDTH), .MSB_FIRST(0)) u_dut_lsb (
      .clk   (clk),
      .reset (reset),
      .bus   (if_lsb)
   );

   always #5 clk = ~clk;

   // Reference model state.
   bit               m_bits[$];
   logic [WIDTH-1:0] m_q_msb, m_q_lsb;
   logic             m_qv, m_ovr, m_pe;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the model by one rising edge with the given inputs.
   task automatic model_edge(input logic s, en, clr, rdy, rst);
      logic             done;
      logic [WIDTH-1:0] w_msb, w_lsb;
      logic             par;
      if (rst) begin
         m_bits.delete();
         m_q_msb = '0; m_q_lsb = '0;
         m_qv = 1'b0; m_ovr = 1'b0; m_pe = 1'b0;
         return;
      end
      done = 1'b0;
      w_msb = '0; w_lsb = '0; par = 1'b0;
      if (clr) begin
         m_bits.delete();
         m_ovr = 1'b0;
      end else if (en) begin
         m_bits.push_back(s);
         if (m_bits.size() == FRAME) begin
            done = 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
               w_msb = (w_msb << 1) | WIDTH'(m_bits[i]);
               w_lsb = w_lsb | (WIDTH'(m_bits[i]) << i);
            end
            for (int i = 0; i < FRAME; i++) par = par ^ m_bits[i];
            m_bits.delete();
         end
      end
      if (done) begin
         if (!m_qv || rdy) begin
            m_q_msb = w_msb; m_q_lsb = w_lsb; m_qv = 1'b1;
            if (FRAME > WIDTH) m_pe = par;
         end else begin
            m_ovr = 1'b1;
         end
      end else if (m_qv && rdy) begin
         m_qv = 1'b0;
      end
   endtask

   task automatic compare_all();
      logic exp_pe;
      exp_pe = (FRAME > WIDTH) ? (m_pe & m_qv) : 1'b0;
      check("msb_q",       32'(if_msb.q),       32'(m_q_msb));
      check("lsb_q",       32'(if_lsb.q),       32'(m_q_lsb));
      check("msb_q_valid", 32'(if_msb.q_valid), 32'(m_qv));
      check("lsb_q_valid", 32'(if_lsb.q_valid), 32'(m_qv));
      check("msb_busy",    32'(if_msb.busy),    32'(m_bits.size() != 0));
      check("lsb_busy",    32'(if_lsb.busy),    32'(m_bits.size() != 0));
      check("msb_overrun", 32'(if_msb.overrun), 32'(m_ovr));
      check("lsb_overrun", 32'(if_lsb.overrun), 32'(m_ovr));
      check("msb_par_err", 32'(if_msb.par_err), 32'(exp_pe));
      check("lsb_par_err", 32'(if_lsb.par_err), 32'(exp_pe));
   endtask

   // Apply inputs, take one edge, update the model and check the outputs 1 ns later.
   task automatic step(input logic s, en, clr, rdy, rst);
      sdi = s; sdi_en = en; clear = clr; q_ready = rdy; reset = rst;
      @(posedge clk);
      model_edge(s, en, clr, rdy, rst);
      #1;
      compare_all();
   endtask

   // Send WIDTH bits. seq[WIDTH-1] goes first. q_ready is rdy_last on the final bit only.
   task automatic send_bits(input logic [WIDTH-1:0] seq, input logic rdy_last);
      for (int i = WIDTH - 1; i >= 0; i--)
         step(seq[i], 1'b1, 1'b0, (i == 0) ? rdy_last : 1'b0, 1'b0);
   endtask

   task automatic consume();
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      sdi = 1'b1; sdi_en = 1'b1; clear = 1'b0; q_ready = 1'b0; reset = 1'b1;

      // Reset held for two cycles with sdi_en active.
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      check("rst_q",       32'(if_msb.q), 32'h0);
      check("rst_q_valid", 32'(if_msb.q_valid), 32'h0);
      check("rst_busy",    32'(if_msb.busy), 32'h0);
      check("rst_overrun", 32'(if_msb.overrun), 32'h0);

`ifndef SIPO_PARITY_EN
      // Basic word 0,1,0,1.
      send_bits(4'b0101, 1'b0);
      check("basic_q",  32'(if_msb.q), 32'h5);
      check("basic_qv", 32'(if_msb.q_valid), 32'h1);
      consume();
      check("basic_taken", 32'(if_msb.q_valid), 32'h0);

      // Bits 1,1,gap,0,1 into the MSB-first receiver.
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("gap_busy", 32'(if_msb.busy), 32'h1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("gap_q", 32'(if_msb.q), 32'hD);
      consume();
      // Bits 1,0,1,0 into the LSB-first receiver.
      send_bits(4'b1010, 1'b0);
      check("lsb_order_q", 32'(if_lsb.q), 32'h5);
      consume();

      // Overrun while the word is held, then clear.
      send_bits(4'b0101, 1'b0);
      send_bits(4'b1111, 1'b0);
      check("ovr_q_held", 32'(if_msb.q), 32'h5);
      check("ovr_flag",   32'(if_msb.overrun), 32'h1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("ovr_cleared",  32'(if_msb.overrun), 32'h0);
      check("ovr_qv_after", 32'(if_msb.q_valid), 32'h1);
      consume();

      // Back-to-back: the consumer accepts on the edge that completes word 2.
      send_bits(4'b0011, 1'b0);
      send_bits(4'b1010, 1'b1);
      check("b2b_q",  32'(if_msb.q), 32'hA);
      check("b2b_qv", 32'(if_msb.q_valid), 32'h1);
      consume();

      // Clear after two bits. The next four bits form a fresh word.
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check("clr_busy", 32'(if_msb.busy), 32'h0);
      send_bits(4'b1001, 1'b0);
      check("clr_fresh_q", 32'(if_msb.q), 32'h9);
      consume();
`else
      // Data 0,1,0,1 with parity 1: odd total, so an error is reported.
      send_bits(4'b0101, 1'b0);
      check("par_busy", 32'(if_msb.busy), 32'h1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("par1_q",   32'(if_msb.q), 32'h5);
      check("par1_err", 32'(if_msb.par_err), 32'h1);
      consume();
      send_bits(4'b0101, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("par0_err", 32'(if_msb.par_err), 32'h0);
      consume();
      // Clear after two bits. The next five bits form a fresh word.
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("par_clr_busy", 32'(if_msb.busy), 32'h0);
      send_bits(4'b1001, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("par_clr_q",   32'(if_msb.q), 32'h9);
      check("par_clr_err", 32'(if_msb.par_err), 32'h1);
      consume();
`endif

      // Randomized traffic, including clears, stalls and occasional resets.
      for (int n = 0; n < 3000; n++) begin
         step(1'($urandom), ($urandom % 3) != 0, ($urandom % 40) == 0,
              ($urandom % 3) == 0, ($urandom % 400) == 0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
